// File: rtl/servo_uart_pkg.sv
// rtl/servo_uart_pkg.sv - shared types and constants for the servo packet receiver
//
// Holds the byte-receiver and parser state types, the default packet sync
// marker, the servo centre position and the packet checksum helper.
// Optional feature macro: SERVO_PKT_CKSUM_EN (adds the GET_CK parser state).

package servo_uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
  localparam logic [7:0] TARGET_CENTRE     = 8'd128;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    HUNT,
    GET_X,
`ifdef SERVO_PKT_CKSUM_EN
    GET_Y,
    GET_CK
`else
    GET_Y
`endif
  } parser_state_t;

  function automatic logic [7:0] pkt_cksum(input logic [7:0] sync,
                                           input logic [7:0] x,
                                           input logic [7:0] y);
    return sync ^ x ^ y;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - centre-sampled 8N1 byte receiver with input synchronizer
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_rx         raw serial line, idle high
//   o_rx_byte    last assembled byte (valid while o_byte_valid is high)
//   o_byte_valid one-cycle pulse: byte received with a good stop bit
//   o_frame_err  one-cycle pulse: stop bit sampled low, byte discarded

module uart_byte_rx
  import servo_uart_pkg::*;
#(
  parameter int BAUD_TICK = 5208
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int CW = (BAUD_TICK > 2) ? $clog2(BAUD_TICK) : 1;
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_TICK - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_TICK / 2 - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_rx_prev;
  rx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_byte_valid;
  logic          r_frame_err;
  logic          w_fall;

  // Start-bit edge is taken on the synchronized line only.
  assign w_fall = r_rx_prev & ~r_sync2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= i_rx;
      r_sync2      <= r_sync1;
      r_rx_prev    <= r_sync2;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_state <= RX_START;
            r_cnt   <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (r_sync2) begin
            // Line back high at mid start bit: a glitch, not a frame.
            r_state <= RX_IDLE;
          end else begin
            r_state   <= RX_DATA;
            r_cnt     <= FULL_LOAD;
            r_bit_idx <= '0;
          end
        end
        RX_DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_cnt     <= FULL_LOAD;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            if (r_sync2) r_byte_valid <= 1'b1;
            else         r_frame_err  <= 1'b1;
            r_state <= RX_IDLE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_rx_byte    = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/servo_packet_rx.sv
// rtl/servo_packet_rx.sv - UART front end and framed X/Y packet parser for the servo path
//
// Packet: SYNC, X, Y (plus CK = SYNC^X^Y when SERVO_PKT_CKSUM_EN is defined).
// Ports:
//   clk50mhz      system clock
//   rst           asynchronous active-high reset
//   uart_rx       serial line, idle high
//   x_target      last accepted X target (reset 128)
//   y_target      last accepted Y target (reset 128)
//   target_valid  one-cycle pulse when the targets update
//   frame_err     one-cycle pulse on a stop bit sampled low
//   cksum_err     one-cycle pulse on checksum mismatch (0 without the macro)

module servo_packet_rx
  import servo_uart_pkg::*;
#(
  parameter int         CLK_FREQ     = 50000000,
  parameter int         BAUD_RATE    = 9600,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       clk50mhz,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] x_target,
  output logic [7:0] y_target,
  output logic       target_valid,
  output logic       frame_err,
  output logic       cksum_err
);

  localparam int BAUD_TICK = CLK_FREQ / BAUD_RATE;
  localparam int GAP_LIMIT = TIMEOUT_BITS * BAUD_TICK;
  localparam int GW        = $clog2(GAP_LIMIT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LIMIT - 1);

  logic [7:0]    w_rx_byte;
  logic          w_byte_valid;
  logic          w_frame_err;
  logic          w_timeout;

  parser_state_t r_state;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_x_tmp;
  logic [7:0]    r_x_target;
  logic [7:0]    r_y_target;
  logic          r_target_valid;
`ifdef SERVO_PKT_CKSUM_EN
  logic [7:0]    r_y_tmp;
  logic          r_cksum_err;
`endif

  uart_byte_rx #(
    .BAUD_TICK (BAUD_TICK)
  ) u_byte_rx (
    .i_clk        (clk50mhz),
    .i_rst        (rst),
    .i_rx         (uart_rx),
    .o_rx_byte    (w_rx_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  // Gap timer reaches the limit on this edge.
  assign w_timeout = (r_state != HUNT) && (r_gap == GAP_LAST);

  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      r_gap <= '0;
    end else if (w_byte_valid || r_state == HUNT || w_timeout) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + GW'(1);
    end
  end

  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      r_state        <= HUNT;
      r_x_tmp        <= '0;
      r_x_target     <= TARGET_CENTRE;
      r_y_target     <= TARGET_CENTRE;
      r_target_valid <= 1'b0;
`ifdef SERVO_PKT_CKSUM_EN
      r_y_tmp        <= '0;
      r_cksum_err    <= 1'b0;
`endif
    end else begin
      r_target_valid <= 1'b0;
`ifdef SERVO_PKT_CKSUM_EN
      r_cksum_err    <= 1'b0;
`endif
      if (w_frame_err) begin
        r_state <= HUNT;
      end else if (w_byte_valid) begin
        // Byte arrival outranks a coincident timeout.
        case (r_state)
          HUNT: begin
            if (w_rx_byte == SYNC_BYTE) r_state <= GET_X;
          end
          GET_X: begin
            r_x_tmp <= w_rx_byte;
            r_state <= GET_Y;
          end
          GET_Y: begin
`ifdef SERVO_PKT_CKSUM_EN
            r_y_tmp <= w_rx_byte;
            r_state <= GET_CK;
`else
            r_x_target     <= r_x_tmp;
            r_y_target     <= w_rx_byte;
            r_target_valid <= 1'b1;
            r_state        <= HUNT;
`endif
          end
`ifdef SERVO_PKT_CKSUM_EN
          GET_CK: begin
            if (w_rx_byte == pkt_cksum(SYNC_BYTE, r_x_tmp, r_y_tmp)) begin
              r_x_target     <= r_x_tmp;
              r_y_target     <= r_y_tmp;
              r_target_valid <= 1'b1;
            end else begin
              r_cksum_err <= 1'b1;
            end
            r_state <= HUNT;
          end
`endif
          default: r_state <= HUNT;
        endcase
      end else if (w_timeout) begin
        r_state <= HUNT;
      end
    end
  end

  assign x_target     = r_x_target;
  assign y_target     = r_y_target;
  assign target_valid = r_target_valid;
  assign frame_err    = w_frame_err;
`ifdef SERVO_PKT_CKSUM_EN
  assign cksum_err    = r_cksum_err;
`else
  assign cksum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_servo_packet_rx.sv
// tb/tb_servo_packet_rx.sv - scoreboard bench for servo_packet_rx (either SERVO_PKT_CKSUM_EN build)

module tb_servo_packet_rx;

  // 1000/48 truncates to 20 clocks per bit; keeps the run short.
  localparam int BIT = 20;

  logic       clk50mhz = 1'b0;
  logic       rst      = 1'b1;
  logic       uart_rx  = 1'b1;
  logic [7:0] x_target;
  logic [7:0] y_target;
  logic       target_valid;
  logic       frame_err;
  logic       cksum_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fe     = 0;
  int n_ck     = 0;
  int exp_ck   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp_entry;
  logic [7:0]  prev_x = 8'd128;
  logic [7:0]  prev_y = 8'd128;
  logic        prev_tv = 1'b0;
  logic        prev_rst = 1'b1;

  servo_packet_rx #(
    .CLK_FREQ     (1000),
    .BAUD_RATE    (48),
    .SYNC_BYTE    (8'hAA),
    .TIMEOUT_BITS (20)
  ) dut (
    .clk50mhz     (clk50mhz),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .x_target     (x_target),
    .y_target     (y_target),
    .target_valid (target_valid),
    .frame_err    (frame_err),
    .cksum_err    (cksum_err)
  );

  always #5 clk50mhz = ~clk50mhz;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * BIT) @(negedge clk50mhz);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk50mhz);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk50mhz);
    end
    uart_rx = stop_bit;
    repeat (BIT) @(negedge clk50mhz);
    idle_bits(1);
  endtask

  task automatic send_good(input logic [7:0] x, input logic [7:0] y);
    exp_q.push_back({x, y});
    send_byte(8'hAA, 1'b1);
    send_byte(x, 1'b1);
    send_byte(y, 1'b1);
`ifdef SERVO_PKT_CKSUM_EN
    send_byte(8'hAA ^ x ^ y, 1'b1);
`endif
  endtask

  // Output monitor: every target_valid pops one expected pair.
  always @(negedge clk50mhz) begin
    if (!rst && !prev_rst) begin
      if (target_valid) begin
        if (exp_q.size() == 0) begin
          check("tv_unexpected", 16'd1, 16'd0);
        end else begin
          exp_entry = exp_q.pop_front();
          check("x_target", {8'd0, x_target}, {8'd0, exp_entry[15:8]});
          check("y_target", {8'd0, y_target}, {8'd0, exp_entry[7:0]});
        end
        check("tv_fe_overlap", {15'd0, frame_err}, 16'd0);
        if (prev_tv) check("tv_width", 16'd2, 16'd1);
      end else begin
        if (x_target != prev_x) check("x_hold", {8'd0, x_target}, {8'd0, prev_x});
        if (y_target != prev_y) check("y_hold", {8'd0, y_target}, {8'd0, prev_y});
      end
      if (frame_err) n_fe++;
      if (cksum_err) n_ck++;
    end
    prev_x   = x_target;
    prev_y   = y_target;
    prev_tv  = target_valid;
    prev_rst = rst;
  end

  initial begin
    repeat (100000) @(posedge clk50mhz);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (10) @(negedge clk50mhz);
    check("rst_x", {8'd0, x_target}, 16'd128);
    check("rst_y", {8'd0, y_target}, 16'd128);
    check("rst_tv", {15'd0, target_valid}, 16'd0);
    check("rst_fe", {15'd0, frame_err}, 16'd0);
    check("rst_ce", {15'd0, cksum_err}, 16'd0);
    rst = 1'b0;
    idle_bits(5);
    check("idle_x", {8'd0, x_target}, 16'd128);

    // Short low glitch must be rejected at mid start bit.
    uart_rx = 1'b0;
    repeat (3) @(negedge clk50mhz);
    idle_bits(2);
    check("glitch_fe", n_fe[15:0], 16'd0);

    send_good(8'h40, 8'hC0);
    check("good_x", {8'd0, x_target}, 16'h40);
    check("good_y", {8'd0, y_target}, 16'hC0);
    check("good_pending", exp_q.size(), 0);

`ifdef SERVO_PKT_CKSUM_EN
    send_byte(8'hAA, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    exp_ck++;
    send_byte(8'h00, 1'b1);
    check("badck_count", n_ck[15:0], exp_ck[15:0]);
    check("badck_x", {8'd0, x_target}, 16'h40);
    check("badck_y", {8'd0, y_target}, 16'hC0);
    send_good(8'h10, 8'h20);
    check("after_badck_x", {8'd0, x_target}, 16'h10);
`endif

    send_byte(8'h55, 1'b1);
    send_good(8'h01, 8'h02);
    check("garbage_x", {8'd0, x_target}, 16'h01);
    check("garbage_y", {8'd0, y_target}, 16'h02);

    send_byte(8'hAA, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h77, 1'b0);
    idle_bits(1);
    check("frame_err_count", n_fe[15:0], 16'd1);
    send_good(8'h12, 8'h34);
    check("after_fe_x", {8'd0, x_target}, 16'h12);
    check("after_fe_y", {8'd0, y_target}, 16'h34);

    send_byte(8'hAA, 1'b1);
    send_byte(8'h33, 1'b1);
    idle_bits(25);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    idle_bits(2);
    check("timeout_x", {8'd0, x_target}, 16'h12);
    check("timeout_y", {8'd0, y_target}, 16'h34);
    send_good(8'h66, 8'h77);
    check("after_to_x", {8'd0, x_target}, 16'h66);
    check("after_to_y", {8'd0, y_target}, 16'h77);

    // Reset in the middle of a packet and a byte.
    send_byte(8'hAA, 1'b1);
    send_byte(8'h11, 1'b1);
    uart_rx = 1'b0;
    repeat (50) @(negedge clk50mhz);
    rst = 1'b1;
    repeat (5) @(negedge clk50mhz);
    check("midrst_x", {8'd0, x_target}, 16'd128);
    check("midrst_y", {8'd0, y_target}, 16'd128);
    uart_rx = 1'b1;
    rst = 1'b0;
    idle_bits(2);
    send_good(8'h5A, 8'hA5);
    check("final_x", {8'd0, x_target}, 16'h5A);
    check("final_y", {8'd0, y_target}, 16'hA5);

    idle_bits(2);
    check("pending_commits", exp_q.size(), 0);
    check("frame_err_total", n_fe[15:0], 16'd1);
    check("cksum_err_total", n_ck[15:0], exp_ck[15:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
